mc_maindec: RTL and testbench

MC_MAINDEC -- requirements
Module: mc_maindec

---
 rtl/mc_maindec.sv | 181 ++++++++++++++++++
 tb/tb_mc_maindec.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mc_maindec.sv
// mc_maindec -- main control decoder for a multicycle MIPS-style datapath.
//
// A registered Moore FSM steps through fetch, decode and the per-class
// execute/memory/writeback states. Control outputs decode from the current
// state. The exceptions are the FETCH strobes (irwrite/pcwrite), which follow
// memready, and illegal_op in DECODE, which depends on op.
//
// Ports
//   clk        : clock, rising edge
//   reset      : synchronous, active-high; next state is FETCH
//   op[5:0]    : instruction opcode, sampled in DECODE (and MEMADR for lw/sw)
//   memready   : memory access complete handshake
//   memtoreg, regdst, iord, alusrca, irwrite, memwrite, pcwrite, branch,
//   regwrite   : single-bit datapath controls
//   pcsrc, alusrcb, aluop : 2-bit datapath selects / ALU class
//   illegal_op : unrecognised opcode seen in DECODE
//   state[3:0] : current FSM state (debug)
module mc_maindec (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       memready,
  output logic       memtoreg,
  output logic       regdst,
  output logic       iord,
  output logic       alusrca,
  output logic       irwrite,
  output logic       memwrite,
  output logic       pcwrite,
  output logic       branch,
  output logic       regwrite,
  output logic [1:0] pcsrc,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic [3:0] w_ostate;  // state used for output decode

  assign state = r_state;

  always_ff @(posedge clk) begin
    if (reset) r_state <= FETCH;
    else       r_state <= w_next;
  end

  // Next-state logic. Encodings 12-15 fall through to FETCH.
  always_comb begin
    w_next = FETCH;
    case (r_state)
      FETCH:    w_next = memready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = MEMADR;
          OP_RTYPE:     w_next = EXECUTE;
          OP_BEQ:       w_next = BRANCH;
          OP_ADDI:      w_next = ADDIEXEC;
          OP_J:         w_next = JUMP;
          default:      w_next = FETCH;
        endcase
      end
      MEMADR:   w_next = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:    w_next = memready ? MEMWB : MEMRD;
      MEMWB:    w_next = FETCH;
      MEMWR:    w_next = memready ? FETCH : MEMWR;
      EXECUTE:  w_next = ALUWB;
      ALUWB:    w_next = FETCH;
      BRANCH:   w_next = FETCH;
      ADDIEXEC: w_next = ADDIWB;
      ADDIWB:   w_next = FETCH;
      JUMP:     w_next = FETCH;
      default:  w_next = FETCH;
    endcase
  end

  // While reset is high the selects show FETCH values so the datapath sees a
  // benign configuration. Write enables are forced low below.
  assign w_ostate = reset ? FETCH : r_state;

  always_comb begin
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    iord       = 1'b0;
    alusrca    = 1'b0;
    irwrite    = 1'b0;
    memwrite   = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    regwrite   = 1'b0;
    pcsrc      = 2'b00;
    alusrcb    = 2'b00;
    aluop      = 2'b00;
    illegal_op = 1'b0;
    case (w_ostate)
      FETCH: begin
        alusrcb = 2'b01;
        irwrite = memready;
        pcwrite = memready;
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal_op = 1'b0;
          default:                                       illegal_op = 1'b1;
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD:  iord = 1'b1;
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      EXECUTE: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BRANCH: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      ADDIEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ADDIWB: regwrite = 1'b1;
      JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
    // Reset aborts any instruction: no strobe may fire while it is held.
    if (reset) begin
      irwrite    = 1'b0;
      pcwrite    = 1'b0;
      memwrite   = 1'b0;
      regwrite   = 1'b0;
      branch     = 1'b0;
      illegal_op = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_maindec.sv
// Directed bench for mc_maindec. Controls are packed as
// {memtoreg,regdst,iord,alusrca,irwrite,memwrite,pcwrite,branch,regwrite,
//  pcsrc[1:0],alusrcb[1:0],aluop[1:0],illegal_op}.
module tb_mc_maindec;
  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       memready;
  logic       memtoreg, regdst, iord, alusrca, irwrite, memwrite, pcwrite;
  logic       branch, regwrite, illegal_op;
  logic [1:0] pcsrc, alusrcb, aluop;
  logic [3:0] state;

  int errs   = 0;
  int checks = 0;

  // Hand-derived control words per state.
  localparam logic [15:0] C_FETCH   = 16'h0A08;  // memready=1
  localparam logic [15:0] C_FETCH0  = 16'h0008;  // memready=0, or in reset
  localparam logic [15:0] C_DECODE  = 16'h0018;
  localparam logic [15:0] C_ILLEGAL = 16'h0019;
  localparam logic [15:0] C_MEMADR  = 16'h1010;
  localparam logic [15:0] C_MEMRD   = 16'h2000;
  localparam logic [15:0] C_MEMWB   = 16'h8080;
  localparam logic [15:0] C_MEMWR   = 16'h2400;
  localparam logic [15:0] C_EXECUTE = 16'h1004;
  localparam logic [15:0] C_ALUWB   = 16'h4080;
  localparam logic [15:0] C_BRANCH  = 16'h1122;
  localparam logic [15:0] C_ADDIEX  = 16'h1010;
  localparam logic [15:0] C_ADDIWB  = 16'h0080;
  localparam logic [15:0] C_JUMP    = 16'h0240;

  logic [15:0] ctl;
  assign ctl = {memtoreg, regdst, iord, alusrca, irwrite, memwrite, pcwrite,
                branch, regwrite, pcsrc, alusrcb, aluop, illegal_op};

  mc_maindec dut (
    .clk(clk), .reset(reset), .op(op), .memready(memready),
    .memtoreg(memtoreg), .regdst(regdst), .iord(iord), .alusrca(alusrca),
    .irwrite(irwrite), .memwrite(memwrite), .pcwrite(pcwrite),
    .branch(branch), .regwrite(regwrite), .pcsrc(pcsrc), .alusrcb(alusrcb),
    .aluop(aluop), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_st(input string tag, input logic [3:0] est,
                           input logic [15:0] ectl);
    checks++;
    assert (state === est) else begin
      errs++;
      $error("FAIL %s.state got=%0d want=%0d", tag, state, est);
    end
    checks++;
    assert (ctl === ectl) else begin
      errs++;
      $error("FAIL %s.ctl got=%h want=%h", tag, ctl, ectl);
    end
  endtask

  initial begin
    reset = 1'b1; op = 6'b000000; memready = 1'b1;
    tick(); tick();
    expect_st("rst", 4'd0, C_FETCH0);
    reset = 1'b0;
    #1;
    expect_st("fetch", 4'd0, C_FETCH);

    // FETCH stalls on memready
    memready = 1'b0;
    #1 expect_st("fstall0", 4'd0, C_FETCH0);
    tick(); expect_st("fstall1", 4'd0, C_FETCH0);
    memready = 1'b1;
    #1 expect_st("fgo", 4'd0, C_FETCH);

    // lw: 0,1,2,3,4,0
    op = 6'b100011;
    tick(); expect_st("lw1", 4'd1, C_DECODE);
    tick(); expect_st("lw2", 4'd2, C_MEMADR);
    tick(); expect_st("lw3", 4'd3, C_MEMRD);
    tick(); expect_st("lw4", 4'd4, C_MEMWB);
    tick(); expect_st("lw0", 4'd0, C_FETCH);

    // R-type: 0,1,6,7,0
    op = 6'b000000;
    tick(); expect_st("r1", 4'd1, C_DECODE);
    tick(); expect_st("r6", 4'd6, C_EXECUTE);
    tick(); expect_st("r7", 4'd7, C_ALUWB);
    tick(); expect_st("r0", 4'd0, C_FETCH);

    // beq: 0,1,8,0
    op = 6'b000100;
    tick(); expect_st("beq1", 4'd1, C_DECODE);
    tick(); expect_st("beq8", 4'd8, C_BRANCH);
    tick(); expect_st("beq0", 4'd0, C_FETCH);

    // j: 0,1,11,0
    op = 6'b000010;
    tick(); expect_st("j1", 4'd1, C_DECODE);
    tick(); expect_st("j11", 4'd11, C_JUMP);
    tick(); expect_st("j0", 4'd0, C_FETCH);

    // addi: 0,1,9,10,0
    op = 6'b001000;
    tick(); expect_st("addi1", 4'd1, C_DECODE);
    tick(); expect_st("addi9", 4'd9, C_ADDIEX);
    tick(); expect_st("addi10", 4'd10, C_ADDIWB);
    tick(); expect_st("addi0", 4'd0, C_FETCH);

    // sw with 3-cycle stall in MEMWR
    op = 6'b101011;
    tick(); expect_st("sw1", 4'd1, C_DECODE);
    tick(); expect_st("sw2", 4'd2, C_MEMADR);
    memready = 1'b0;
    tick(); expect_st("sw5a", 4'd5, C_MEMWR);
    tick(); expect_st("sw5b", 4'd5, C_MEMWR);
    tick(); expect_st("sw5c", 4'd5, C_MEMWR);
    memready = 1'b1;
    #1 expect_st("sw5rdy", 4'd5, C_MEMWR);
    tick(); expect_st("sw0", 4'd0, C_FETCH);

    // illegal opcode: flag only in DECODE, then back to FETCH
    op = 6'b111111;
    tick(); expect_st("ill1", 4'd1, C_ILLEGAL);
    tick(); expect_st("ill0", 4'd0, C_FETCH);

    // reset during a MEMRD stall
    op = 6'b100011;
    tick(); expect_st("mr1", 4'd1, C_DECODE);
    tick(); expect_st("mr2", 4'd2, C_MEMADR);
    memready = 1'b0;
    tick(); expect_st("mr3", 4'd3, C_MEMRD);
    reset = 1'b1;
    #1 expect_st("mr3rst", 4'd3, C_FETCH0);
    tick(); expect_st("mrrst0", 4'd0, C_FETCH0);
    reset = 1'b0;
    tick(); expect_st("mrhold", 4'd0, C_FETCH0);
    memready = 1'b1;
    #1 expect_st("mrgo", 4'd0, C_FETCH);

    // reset during a MEMWR stall
    op = 6'b101011;
    tick(); expect_st("wr1", 4'd1, C_DECODE);
    tick(); expect_st("wr2", 4'd2, C_MEMADR);
    memready = 1'b0;
    tick(); expect_st("wr5", 4'd5, C_MEMWR);
    reset = 1'b1;
    #1 expect_st("wr5rst", 4'd5, C_FETCH0);
    tick(); expect_st("wrrst0", 4'd0, C_FETCH0);
    reset = 1'b0; memready = 1'b1;
    #1 expect_st("wrgo", 4'd0, C_FETCH);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
